// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow, synchronous flush and registered or fall-through read port.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] AF_T = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH-1) begin : g_bad_thresh
    $fatal(1, "sync_fifo_ctrl: illegal AF_THRESH/AE_THRESH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr, rptr, cnt_q;
  logic                  wr_ok, rd_ok;
  logic                  ovf_q, unf_q;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                 (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign empty = (wptr == rptr);
  assign rd_ok = r_en & ~empty;
  assign wr_ok = w_en & (~full | rd_ok);

  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= AF_T);
  assign almost_empty = (cnt_q <= AE_T);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (w_en && !wr_ok) ovf_q <= 1'b1;
      if (r_en && !rd_ok) unf_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wptr[PTR_WIDTH-1:0]] <= data_in;
  end

  if (FWFT == 1'b0) begin : g_reg_rd
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  vld_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (clr) begin
        vld_q  <= 1'b0;
      end else if (rd_ok) begin
        dout_q <= mem[rptr[PTR_WIDTH-1:0]];
        vld_q  <= 1'b1;
      end else begin
        vld_q  <= 1'b0;
      end
    end
    assign data_out = dout_q;
    assign rd_valid = vld_q;
  end else begin : g_fwft_rd
    // Head word is presented directly; zero while empty so reset shows 0.
    assign data_out = empty ? '0 : mem[rptr[PTR_WIDTH-1:0]];
    assign rd_valid = ~empty;
  end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench: registered-read and FWFT instances share stimulus; a monitor
// pops expected read data whenever the registered-read instance flags rd_valid.
module tb_sync_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] do0, do1;
  logic       v0, full0, empty0, af0, ae0, ov0, un0;
  logic       v1, full1, empty1, af1, ae1, ov1, un1;
  logic [3:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(do0), .rd_valid(v0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(do1), .rd_valid(v1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the capturing edge.
  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
    w_en = w; data_in = d; r_en = r; clr = c;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && v0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got %0h want none", do0);
      end else begin
        chk("rd_data", do0, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic rdk, rok, wok;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // reset state
    chk("rst_empty", empty0, 1); chk("rst_full", full0, 0); chk("rst_count", cnt0, 0);
    chk("rst_valid", v0, 0); chk("rst_dout", do0, 0); chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0); chk("rst_ov", ov0, 0); chk("rst_un", un0, 0);

    // T2 fill / drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("fill_count", cnt0, i);
      chk("fill_af", af0, int'(i >= 6));
      chk("fill_ae", ae0, int'(i <= 2));
      chk("fill_full", full0, int'(i == 8));
    end
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      cyc(0, 0, 1, 0);
      chk("drain_count", cnt0, 8 - i);
      chk("drain_empty", empty0, int'(i == 8));
    end
    cyc(0, 0, 0, 0);
    chk("drain_vld_low", v0, 0);
    chk("drain_dout_hold", do0, 8'h08);

    // T3 overflow / underflow
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    chk("ovf_flag", ov0, 1); chk("ovf_count", cnt0, 8); chk("ovf_full", full0, 1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      cyc(0, 0, 1, 0);
    end
    cyc(0, 0, 1, 0);
    chk("unf_flag", un0, 1); chk("unf_count", cnt0, 0); chk("unf_vld", v0, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_held", ov0, 1); chk("unf_held", un0, 1);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", ov0, 0); chk("clr_unf", un0, 0); chk("clr_count", cnt0, 0);

    // T4 simultaneous read+write at full and at empty
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    exp_q.push_back(8'h20);
    cyc(1, 8'h30, 1, 0);
    chk("simf_count", cnt0, 8); chk("simf_full", full0, 1); chk("simf_ov", ov0, 0);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      cyc(0, 0, 1, 0);
    end
    exp_q.push_back(8'h30);
    cyc(0, 0, 1, 0);
    chk("sime_pre_empty", empty0, 1);
    cyc(1, 8'h40, 1, 0);
    chk("sime_count", cnt0, 1); chk("sime_unf", un0, 1); chk("sime_empty", empty0, 0);
    exp_q.push_back(8'h40);
    cyc(0, 0, 1, 0);
    chk("sime_drained", cnt0, 0);
    cyc(0, 0, 0, 1);

    // T5 interleaved traffic wrapping the pointers
    for (int k = 0; k < 20; k++) begin
      rdk = (k % 3) != 0;
      rok = rdk && (mq.size() > 0);
      wok = (mq.size() < 8) || rok;
      if (rok) exp_q.push_back(mq.pop_front());
      if (wok) mq.push_back(8'(8'h50 + k));
      cyc(1, 8'(8'h50 + k), rdk, 0);
      chk("wrap_count", cnt0, mq.size());
    end
    while (mq.size() > 0) begin
      exp_q.push_back(mq.pop_front());
      cyc(0, 0, 1, 0);
      chk("wrap_drain_count", cnt0, mq.size());
    end
    cyc(0, 0, 0, 0);
    chk("sb_drained", exp_q.size(), 0);
    chk("wrap_unf", un0, 0);

    // T6 first-word-fall-through instance
    mon_en = 1'b0;
    cyc(0, 0, 0, 1);
    chk("fw_empty_vld", v1, 0);
    cyc(1, 8'h5A, 0, 0);
    chk("fw_data", do1, 8'h5A); chk("fw_vld", v1, 1);
    cyc(0, 0, 1, 0);
    chk("fw_pop_vld", v1, 0); chk("fw_pop_empty", empty1, 1);
    cyc(1, 8'h66, 0, 0);
    cyc(1, 8'h77, 0, 0);
    chk("fw_head0", do1, 8'h66);
    cyc(0, 0, 1, 0);
    chk("fw_head1", do1, 8'h77); chk("fw_cnt1", cnt1, 1);
    cyc(1, 8'h99, 0, 1);
    chk("fw_clr_count", cnt1, 0); chk("fw_clr_vld", v1, 0);
    cyc(0, 0, 0, 0);
    chk("fw_clr_dropped", cnt1, 0);

    // T1 asynchronous reset in the middle of a read
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(0, 0, 1, 0);
    chk("mid_vld_pre", v0, 1); chk("mid_dout_pre", do0, 8'h11);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_empty", empty0, 1); chk("mid_full", full0, 0); chk("mid_count", cnt0, 0);
    chk("mid_vld", v0, 0); chk("mid_dout", do0, 0); chk("mid_fw_vld", v1, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
